// File: rtl/stage_sequencer_if.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
//  Module   : stage_sequencer_if
//  Purpose  : Bundles the control handshake between the ARM-LP controller
//             side and the stage sequencer.
//  Signals  : start, haltReq, memReady, memReadFlag, memWriteFlag,
//             regWriteFlag                   -> into the sequencer
//             fetchEn, decodeEn, executeEn, memEn, writeBackEn, pcUpdateEn,
//             stage[2:0], busy, memFault, retiredCount[CNT_W-1:0]
//                                            <- out of the sequencer
//  Modports : master = controller/datapath side, slave = sequencer side
//  Revision : 1.0 - initial release
// ============================================================================
interface stage_sequencer_if #(
    parameter int CNT_W = 32
);
    logic             start;
    logic             haltReq;
    logic             memReady;
    logic             memReadFlag;
    logic             memWriteFlag;
    logic             regWriteFlag;

    logic             fetchEn;
    logic             decodeEn;
    logic             executeEn;
    logic             memEn;
    logic             writeBackEn;
    logic             pcUpdateEn;
    logic [2:0]       stage;
    logic             busy;
    logic             memFault;
    logic [CNT_W-1:0] retiredCount;

    modport master (
        output start, haltReq, memReady, memReadFlag, memWriteFlag, regWriteFlag,
        input  fetchEn, decodeEn, executeEn, memEn, writeBackEn, pcUpdateEn,
        input  stage, busy, memFault, retiredCount
    );

    modport slave (
        input  start, haltReq, memReady, memReadFlag, memWriteFlag, regWriteFlag,
        output fetchEn, decodeEn, executeEn, memEn, writeBackEn, pcUpdateEn,
        output stage, busy, memFault, retiredCount
    );
endinterface
`default_nettype wire

// File: rtl/stage_sequencer.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
//  Module   : stage_sequencer
//  Purpose  : Multi-cycle stage sequencer for the ARM-LP datapath. Issues
//             one-hot stage enables, stretches FETCH/MEMORY until the cache
//             reports ready (with a wait timeout that traps into FAULT) and
//             counts retired instructions.
//  Ports    : clock   - rising-edge processor clock
//             resetN  - asynchronous active-low reset
//             bus     - stage_sequencer_if.slave (flags in, enables/status out)
//  Params   : CNT_W       - width of retiredCount
//             MEM_TIMEOUT - wait cycles tolerated in FETCH/MEMORY (1..255)
//  Revision : 1.0 - initial release
// ============================================================================
module stage_sequencer #(
    parameter int CNT_W       = 32,
    parameter int MEM_TIMEOUT = 15
) (
    input  wire logic         clock,
    input  wire logic         resetN,
    stage_sequencer_if.slave  bus
);

    typedef enum logic [2:0] {
        IDLE      = 3'd0,
        FETCH     = 3'd1,
        DECODE    = 3'd2,
        EXECUTE   = 3'd3,
        MEMORY    = 3'd4,
        WRITEBACK = 3'd5,
        HALT      = 3'd6,
        FAULT     = 3'd7
    } state_t;

    // A wait cycle that sees wait_cnt == WAIT_LAST is the MEM_TIMEOUT-th one.
    localparam logic [7:0] WAIT_LAST = 8'(MEM_TIMEOUT - 1);

    state_t           state;
    state_t           next_state;
    logic [7:0]       wait_cnt;
    logic [7:0]       next_wait;
    logic             ld_r;
    logic             st_w;
    logic             rg_w;
    logic [CNT_W-1:0] retired;

    // ------------------------------------------------------------------
    // State, wait counter, latched decode flags, retirement counter
    // ------------------------------------------------------------------
    always_ff @(posedge clock or negedge resetN) begin
        if (!resetN) begin
            state    <= IDLE;
            wait_cnt <= '0;
            ld_r     <= 1'b0;
            st_w     <= 1'b0;
            rg_w     <= 1'b0;
            retired  <= '0;
        end else begin
            state    <= next_state;
            wait_cnt <= next_wait;
            // Flags are captured once and held until the next DECODE so the
            // controller may move on without disturbing this instruction.
            if (state == DECODE) begin
                ld_r <= bus.memReadFlag;
                st_w <= bus.memWriteFlag;
                rg_w <= bus.regWriteFlag;
            end
            if (state == WRITEBACK) begin
                retired <= retired + 1'b1;
            end
        end
    end

    // ------------------------------------------------------------------
    // Next-state logic. next_wait defaults to zero so the counter clears on
    // every transition; it only advances while stalled on memReady.
    // memReady is tested before the timeout, so ready wins a tie.
    // ------------------------------------------------------------------
    always_comb begin
        next_state = state;
        next_wait  = '0;
        unique case (state)
            IDLE: begin
                if (bus.start) next_state = FETCH;
            end
            FETCH: begin
                if (bus.memReady) begin
                    next_state = DECODE;
                end else if (wait_cnt == WAIT_LAST) begin
                    next_state = FAULT;
                end else begin
                    next_wait = wait_cnt + 8'd1;
                end
            end
            DECODE: begin
                next_state = EXECUTE;
            end
            EXECUTE: begin
                next_state = (ld_r || st_w) ? MEMORY : WRITEBACK;
            end
            MEMORY: begin
                if (bus.memReady) begin
                    next_state = WRITEBACK;
                end else if (wait_cnt == WAIT_LAST) begin
                    next_state = FAULT;
                end else begin
                    next_wait = wait_cnt + 8'd1;
                end
            end
            WRITEBACK: begin
                next_state = bus.haltReq ? HALT : FETCH;
            end
            HALT: begin
                if (bus.start) next_state = FETCH;
            end
            FAULT: begin
                next_state = FAULT;
            end
            default: begin
                next_state = IDLE;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // Moore outputs: decoded only from registered state and latched flags.
    // FAULT is left only through reset, so memFault is sticky by design.
    // ------------------------------------------------------------------
    assign bus.fetchEn      = (state == FETCH);
    assign bus.decodeEn     = (state == DECODE);
    assign bus.executeEn    = (state == EXECUTE);
    assign bus.memEn        = (state == MEMORY);
    assign bus.writeBackEn  = (state == WRITEBACK) && rg_w;
    assign bus.pcUpdateEn   = (state == WRITEBACK);
    assign bus.stage        = state;
    assign bus.busy         = (state != IDLE) && (state != HALT) && (state != FAULT);
    assign bus.memFault     = (state == FAULT);
    assign bus.retiredCount = retired;

endmodule
`default_nettype wire

// File: tb/tb_stage_sequencer.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
//  Module   : tb_stage_sequencer
//  Purpose  : Self-checking bench for stage_sequencer. Two instances share
//             one stimulus: dut_a (CNT_W=32, MEM_TIMEOUT=15) and
//             dut_b (CNT_W=4, MEM_TIMEOUT=4) for timeout and wrap cases.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_stage_sequencer;

    logic clk;
    logic rst_n;
    logic start, halt_req, mem_ready, rd_flag, wr_flag, rg_flag;

    int total_cnt = 0;
    int pass_cnt  = 0;

    stage_sequencer_if #(.CNT_W(32)) bus_a ();
    stage_sequencer_if #(.CNT_W(4))  bus_b ();

    assign bus_a.start        = start;
    assign bus_a.haltReq      = halt_req;
    assign bus_a.memReady     = mem_ready;
    assign bus_a.memReadFlag  = rd_flag;
    assign bus_a.memWriteFlag = wr_flag;
    assign bus_a.regWriteFlag = rg_flag;
    assign bus_b.start        = start;
    assign bus_b.haltReq      = halt_req;
    assign bus_b.memReady     = mem_ready;
    assign bus_b.memReadFlag  = rd_flag;
    assign bus_b.memWriteFlag = wr_flag;
    assign bus_b.regWriteFlag = rg_flag;

    stage_sequencer #(.CNT_W(32), .MEM_TIMEOUT(15)) dut_a (
        .clock (clk),
        .resetN(rst_n),
        .bus   (bus_a.slave)
    );

    stage_sequencer #(.CNT_W(4), .MEM_TIMEOUT(4)) dut_b (
        .clock (clk),
        .resetN(rst_n),
        .bus   (bus_b.slave)
    );

    logic [5:0] en_a, en_b;
    assign en_a = {bus_a.fetchEn, bus_a.decodeEn, bus_a.executeEn,
                   bus_a.memEn, bus_a.writeBackEn, bus_a.pcUpdateEn};
    assign en_b = {bus_b.fetchEn, bus_b.decodeEn, bus_b.executeEn,
                   bus_b.memEn, bus_b.writeBackEn, bus_b.pcUpdateEn};

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    typedef struct {
        logic       st, hr, rdy, rd, wr, rg;
        logic [2:0] stg;
        logic       wb;
        int         cnt;
    } vec_t;

    vec_t tbl[$];

    function automatic vec_t mk(input logic st, hr, rdy, rd, wr, rg,
                                input logic [2:0] stg, input logic wb, input int cnt);
        vec_t v;
        v.st = st; v.hr = hr; v.rdy = rdy; v.rd = rd; v.wr = wr; v.rg = rg;
        v.stg = stg; v.wb = wb; v.cnt = cnt;
        return v;
    endfunction

    // Expected enables {fetch, decode, execute, mem, writeBack, pcUpdate}
    function automatic logic [5:0] en_of(input logic [2:0] s, input logic wb);
        case (s)
            3'd1:    return 6'b100000;
            3'd2:    return 6'b010000;
            3'd3:    return 6'b001000;
            3'd4:    return 6'b000100;
            3'd5:    return {4'b0000, wb, 1'b1};
            default: return 6'b000000;
        endcase
    endfunction

    function automatic logic busy_of(input logic [2:0] s);
        return (s >= 3'd1) && (s <= 3'd5);
    endfunction

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        total_cnt++;
        if (got === exp) pass_cnt++;
        else $display("FAIL %s: got %0h expected %0h", name, got, exp);
    endtask

    task automatic step(input logic st, hr, rdy, rd, wr, rg);
        start = st; halt_req = hr; mem_ready = rdy;
        rd_flag = rd; wr_flag = wr; rg_flag = rg;
        @(posedge clk);
        #1;
    endtask

    initial begin
        start = 0; halt_req = 0; mem_ready = 1; rd_flag = 0; wr_flag = 0; rg_flag = 0;
        rst_n = 1'b0;
        repeat (2) @(posedge clk);
        #1;

        // ---------------- reset state ----------------
        check("reset stage",   32'(bus_a.stage), 32'd0);
        check("reset enables", 32'(en_a), 32'd0);
        check("reset busy",    32'(bus_a.busy), 32'd0);
        check("reset fault",   32'(bus_a.memFault), 32'd0);
        check("reset count",   bus_a.retiredCount, 32'd0);
        rst_n = 1'b1;

        // ---------------- directed table (dut_a) ----------------
        //               st hr rdy rd wr rg  stg wb cnt
        tbl.push_back(mk(0, 0, 1, 0, 0, 1, 3'd0, 0, 0));  // IDLE holds
        // two ADDs
        tbl.push_back(mk(1, 0, 1, 0, 0, 1, 3'd1, 0, 0));
        tbl.push_back(mk(0, 0, 1, 0, 0, 1, 3'd2, 0, 0));
        tbl.push_back(mk(0, 0, 1, 0, 0, 1, 3'd3, 0, 0));
        tbl.push_back(mk(0, 0, 1, 0, 0, 1, 3'd5, 1, 0));
        tbl.push_back(mk(0, 0, 1, 0, 0, 1, 3'd1, 0, 1));
        tbl.push_back(mk(0, 0, 1, 0, 0, 1, 3'd2, 0, 1));
        tbl.push_back(mk(0, 0, 1, 0, 0, 1, 3'd3, 0, 1));
        tbl.push_back(mk(0, 0, 1, 0, 0, 1, 3'd5, 1, 1));
        tbl.push_back(mk(0, 0, 1, 0, 0, 1, 3'd1, 0, 2));
        // LDUR
        tbl.push_back(mk(0, 0, 1, 1, 0, 1, 3'd2, 0, 2));
        tbl.push_back(mk(0, 0, 1, 1, 0, 1, 3'd3, 0, 2));
        tbl.push_back(mk(0, 0, 1, 1, 0, 1, 3'd4, 0, 2));
        tbl.push_back(mk(0, 0, 1, 1, 0, 1, 3'd5, 1, 2));
        tbl.push_back(mk(0, 0, 1, 0, 1, 0, 3'd1, 0, 3));
        // STUR; controller flags change after DECODE but latched rgW stays 0
        tbl.push_back(mk(0, 0, 1, 0, 1, 0, 3'd2, 0, 3));
        tbl.push_back(mk(0, 0, 1, 0, 1, 0, 3'd3, 0, 3));
        tbl.push_back(mk(0, 0, 1, 0, 1, 1, 3'd4, 0, 3));
        tbl.push_back(mk(0, 0, 1, 0, 0, 1, 3'd5, 0, 3));
        tbl.push_back(mk(0, 0, 1, 0, 0, 1, 3'd1, 0, 4));
        // FETCH stalled 3 cycles, EXECUTE haltReq pulse ignored
        tbl.push_back(mk(0, 0, 0, 0, 0, 1, 3'd1, 0, 4));
        tbl.push_back(mk(0, 0, 0, 0, 0, 1, 3'd1, 0, 4));
        tbl.push_back(mk(0, 0, 0, 0, 0, 1, 3'd1, 0, 4));
        tbl.push_back(mk(0, 0, 1, 0, 0, 1, 3'd2, 0, 4));
        tbl.push_back(mk(0, 0, 1, 0, 0, 1, 3'd3, 0, 4));
        tbl.push_back(mk(0, 1, 1, 0, 0, 1, 3'd5, 1, 4));
        tbl.push_back(mk(0, 0, 1, 0, 0, 1, 3'd1, 0, 5));
        // haltReq held through WRITEBACK -> HALT, start+haltReq -> FETCH
        tbl.push_back(mk(0, 0, 1, 0, 0, 1, 3'd2, 0, 5));
        tbl.push_back(mk(0, 0, 1, 0, 0, 1, 3'd3, 0, 5));
        tbl.push_back(mk(0, 1, 1, 0, 0, 1, 3'd5, 1, 5));
        tbl.push_back(mk(0, 1, 1, 0, 0, 1, 3'd6, 0, 6));
        tbl.push_back(mk(0, 1, 1, 0, 0, 1, 3'd6, 0, 6));
        tbl.push_back(mk(0, 0, 1, 0, 0, 1, 3'd6, 0, 6));
        tbl.push_back(mk(1, 1, 1, 0, 0, 1, 3'd1, 0, 6));
        tbl.push_back(mk(0, 0, 1, 0, 0, 1, 3'd2, 0, 6));
        tbl.push_back(mk(0, 0, 1, 0, 0, 1, 3'd3, 0, 6));
        tbl.push_back(mk(0, 0, 1, 0, 0, 1, 3'd5, 1, 6));
        tbl.push_back(mk(0, 0, 1, 0, 0, 1, 3'd1, 0, 7));

        for (int i = 0; i < tbl.size(); i++) begin
            step(tbl[i].st, tbl[i].hr, tbl[i].rdy, tbl[i].rd, tbl[i].wr, tbl[i].rg);
            check($sformatf("row%0d stage", i),   32'(bus_a.stage), 32'(tbl[i].stg));
            check($sformatf("row%0d enables", i), 32'(en_a), 32'(en_of(tbl[i].stg, tbl[i].wb)));
            check($sformatf("row%0d busy", i),    32'(bus_a.busy), 32'(busy_of(tbl[i].stg)));
            check($sformatf("row%0d fault", i),   32'(bus_a.memFault), 32'd0);
            check($sformatf("row%0d count", i),   bus_a.retiredCount, 32'(tbl[i].cnt));
        end

        // ---------------- MEMORY timeout on dut_b (MEM_TIMEOUT=4) ----------------
        step(0, 0, 1, 1, 0, 1);                  // -> DECODE
        step(0, 0, 1, 1, 0, 1);                  // -> EXECUTE
        step(0, 0, 1, 1, 0, 1);                  // -> MEMORY
        check("b in memory", 32'(bus_b.stage), 32'd4);
        repeat (3) step(0, 0, 0, 0, 0, 0);
        check("b 3 waits still memory", 32'(bus_b.stage), 32'd4);
        step(0, 0, 0, 0, 0, 0);
        check("b 4 waits fault stage", 32'(bus_b.stage), 32'd7);
        check("b memFault",            32'(bus_b.memFault), 32'd1);
        check("b fault enables",       32'(en_b), 32'd0);
        check("b fault busy",          32'(bus_b.busy), 32'd0);
        check("a still waiting",       32'(bus_a.stage), 32'd4);
        step(1, 0, 0, 0, 0, 0);
        check("b start ignored in fault", 32'(bus_b.stage), 32'd7);
        check("b fault sticky",           32'(bus_b.memFault), 32'd1);

        // ---------------- async reset between edges, dut_a mid-MEMORY ----------------
        #2;
        rst_n = 1'b0;
        #1;
        check("async reset a stage", 32'(bus_a.stage), 32'd0);
        check("async reset a memEn", 32'(bus_a.memEn), 32'd0);
        check("async reset a count", bus_a.retiredCount, 32'd0);
        check("async reset b fault", 32'(bus_b.memFault), 32'd0);
        check("async reset b stage", 32'(bus_b.stage), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;

        // ---------------- ready on the timeout edge wins (dut_b) ----------------
        step(1, 0, 1, 1, 0, 1);                  // -> FETCH
        step(0, 0, 1, 1, 0, 1);                  // -> DECODE
        step(0, 0, 1, 1, 0, 1);                  // -> EXECUTE
        step(0, 0, 1, 1, 0, 1);                  // -> MEMORY
        repeat (3) step(0, 0, 0, 0, 0, 0);
        step(0, 0, 1, 0, 0, 0);
        check("b ready at timeout stage", 32'(bus_b.stage), 32'd5);
        check("b ready at timeout fault", 32'(bus_b.memFault), 32'd0);
        check("b load writeBackEn",       32'(bus_b.writeBackEn), 32'd1);
        step(0, 0, 1, 0, 0, 1);
        check("b count after load", 32'(bus_b.retiredCount), 32'd1);

        // ---------------- counter wrap on dut_b (CNT_W=4) ----------------
        for (int k = 0; k < 15; k++) begin
            repeat (4) step(0, 0, 1, 0, 0, 1);
            if (k == 13) check("b count at 15", 32'(bus_b.retiredCount), 32'd15);
        end
        check("b count wraps to 0", 32'(bus_b.retiredCount), 32'd0);
        check("a count 16",         bus_a.retiredCount, 32'd16);
        check("a back in fetch",    32'(bus_a.stage), 32'd1);

        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/stage_sequencer.md
Name: stage_sequencer

Overview:
Multi-cycle sequencer for the ARM-LP datapath. It replaces free-running, every-edge operation of the instruction cache, controller, operand prep, ALU, data cache and PC with one-hot stage enables. It also stretches the fetch and memory stages until the caches signal ready, and counts retired instructions. It sits beside the controller: it consumes the decoded flags and drives the enable inputs of every datapath unit.

Parameters:
CNT_W, 32, width of retiredCount.
MEM_TIMEOUT, 15, maximum wait cycles in FETCH or MEMORY before a fault (legal range 1..255).

Ports:
clock  input  1  processor clock, rising edge.
resetN  input  1  asynchronous active-low reset.
start  input  1  leave IDLE or HALT and begin fetching.
haltReq  input  1  stop after the current instruction retires.
memReady  input  1  cache access complete (instruction cache in FETCH, data cache in MEMORY).
memReadFlag  input  1  decoded load flag from the controller.
memWriteFlag  input  1  decoded store flag from the controller.
regWriteFlag  input  1  decoded register-write flag.
fetchEn  output  1  instruction cache enable.
decodeEn  output  1  controller/operand-prep read enable.
executeEn  output  1  ALU enable.
memEn  output  1  data cache enable.
writeBackEn  output  1  register file write enable.
pcUpdateEn  output  1  PC advance/branch enable.
stage  output  3  current state encoding.
busy  output  1  high in FETCH..WRITEBACK.
memFault  output  1  sticky wait-timeout fault.
retiredCount  output  CNT_W  instructions retired.

Behaviour:
- States and stage encodings: IDLE=0, FETCH=1, DECODE=2, EXECUTE=3, MEMORY=4, WRITEBACK=5, HALT=6, FAULT=7.
- Reset (resetN=0, asynchronous):
  - state=IDLE, all enables 0, busy=0, memFault=0, retiredCount=0, wait counter=0, latched flags=0.
  - Reset mid-instruction abandons the instruction; it is not counted.
- All outputs are Moore outputs, decoded from registered state and latched flags. No combinational path from inputs to outputs.
- IDLE: start=1 -> FETCH next edge; otherwise stay.
- FETCH: fetchEn=1.
  - memReady=1 -> DECODE.
  - Otherwise the wait counter increments; when it reaches MEM_TIMEOUT with memReady still 0 -> FAULT.
- DECODE: decodeEn=1. On the exit edge, latch memReadFlag, memWriteFlag and regWriteFlag into ldR, stW, rgW. Always -> EXECUTE.
- EXECUTE: executeEn=1.
  - (ldR|stW)=1 -> MEMORY.
  - Otherwise -> WRITEBACK.
- MEMORY: memEn=1, with the same ready/timeout rule as FETCH. memReady=1 -> WRITEBACK.
- WRITEBACK: writeBackEn=rgW, pcUpdateEn=1.
  - Exit edge: retiredCount+1, wrapping modulo 2^CNT_W.
  - haltReq=1 -> HALT; else -> FETCH.
- HALT: all enables 0, busy=0. start=1 -> FETCH; start and haltReq both 1 -> FETCH (start wins).
- FAULT: memFault=1, all enables 0, busy=0. Stays until reset; start is ignored.
- Wait counter:
  - 8 bits; cleared on every state change.
  - Counts only in FETCH and MEMORY while memReady=0.
  - memReady=1 on the same edge that the counter reaches MEM_TIMEOUT -> ready wins, no fault.
- haltReq is sampled only in WRITEBACK; pulses in other states are ignored.
- Latency with memReady tied high:
  - ALU instruction: 4 cycles (FETCH, DECODE, EXECUTE, WRITEBACK).
  - Load/store: 5 cycles.
  - Each low cycle of memReady adds 1 cycle.
- Exactly one of fetchEn, decodeEn, executeEn, memEn, or the WRITEBACK group is active per cycle. pcUpdateEn is high only in WRITEBACK.
- Latched flags stay stable from DECODE exit through WRITEBACK, even if the controller flags change.

Test Plan:
- Reset then start pulse, memReady=1, ADD decoded (regWrite=1) -> stage 1,2,3,5,1..., writeBackEn=1 in cycle 4, retiredCount=1 after 4 cycles, 2 after 8.
- LDUR (memRead=1, regWrite=1) then STUR (memWrite=1, regWrite=0), memReady=1 -> each visits MEMORY; STUR has writeBackEn=0 and pcUpdateEn=1; 10 cycles total for both; retiredCount=2.
- memReady low for 3 cycles in FETCH, MEM_TIMEOUT=15 -> FETCH held 4 cycles; then normal; no fault.
- memReady held low in MEMORY, MEM_TIMEOUT=4 -> FAULT after 4 wait cycles; memFault=1, enables 0; start ignored; resetN low clears to IDLE with memFault=0.
- haltReq pulsed during EXECUTE -> ignored; haltReq held through WRITEBACK -> HALT, busy=0, count frozen; later start -> FETCH; retiredCount continues from its frozen value.
- resetN asserted asynchronously mid-MEMORY (between edges) -> outputs clear immediately; retiredCount=0. CNT_W=4 with 16 retirements -> retiredCount wraps to 0.
